// File: rtl/cell_pos_streamer.sv
// cell_pos_streamer: fetches a cell's particle count, then streams positions through a credit-guarded output FIFO
module cell_pos_streamer #(
    parameter int DATA_WIDTH   = 96,
    parameter int ADDR_WIDTH   = 8,
    parameter int PARTICLE_NUM = 220,
    parameter int RD_LATENCY   = 2,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  count_err,
    output logic [ADDR_WIDTH-1:0] particle_count,
    output logic                  rd_en,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [DATA_WIDTH-1:0] rd_data,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [ADDR_WIDTH-1:0] out_index,
    output logic                  out_valid,
    input  logic                  out_ready
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] MAX_CNT = ADDR_WIDTH'(PARTICLE_NUM - 1);
    localparam logic [ADDR_WIDTH-1:0] ONE = ADDR_WIDTH'(1);
    typedef enum logic [2:0] {IDLE, CNT_RD, CNT_WAIT, STREAM, DRAIN, FIN} state_t;
    state_t state;
    logic [RD_LATENCY-1:0] sr_v;
    logic [ADDR_WIDTH-1:0] sr_a [RD_LATENCY];
    logic [DATA_WIDTH-1:0] f_data [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0] f_idx [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [PW:0] f_cnt;
    logic [ADDR_WIDTH-1:0] next_addr, raw, clamped, tail_a;
    logic tail_v, push, pop, credit, drained;
    logic [7:0] load;
    assign tail_v = sr_v[RD_LATENCY-1];
    assign tail_a = sr_a[RD_LATENCY-1];
    assign push = tail_v && tail_a != '0;
    assign out_valid = f_cnt != '0;
    assign pop = out_valid && out_ready;
    assign out_data = f_data[rd_ptr];
    assign out_index = f_idx[rd_ptr];
    assign raw = rd_data[ADDR_WIDTH-1:0];
    assign clamped = raw > MAX_CNT ? MAX_CNT : raw;
    // A slot being popped this cycle is already free, which keeps one read per cycle sustainable
    always_comb begin
        load = 8'(f_cnt) - 8'(pop) + 8'(rd_en);
        for (int i = 0; i < RD_LATENCY; i++) load = load + 8'(sr_v[i]);
    end
    assign credit = load < 8'(FIFO_DEPTH);
    assign drained = !rd_en && sr_v == '0 && 8'(f_cnt) + 8'(push) - 8'(pop) == 8'd0;
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            busy <= 1'b0;
            done <= 1'b0;
            count_err <= 1'b0;
            particle_count <= '0;
            rd_en <= 1'b0;
            rd_addr <= '0;
            next_addr <= '0;
            sr_v <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            f_cnt <= '0;
            for (int i = 0; i < RD_LATENCY; i++) sr_a[i] <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                f_data[i] <= '0;
                f_idx[i] <= '0;
            end
        end else begin
            sr_v[0] <= rd_en;
            sr_a[0] <= rd_addr;
            for (int i = 1; i < RD_LATENCY; i++) begin
                sr_v[i] <= sr_v[i-1];
                sr_a[i] <= sr_a[i-1];
            end
            if (push) begin
                f_data[wr_ptr] <= rd_data;
                f_idx[wr_ptr] <= tail_a;
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            f_cnt <= f_cnt + (PW+1)'(push) - (PW+1)'(pop);
            done <= 1'b0;
            rd_en <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    state <= CNT_RD;
                    busy <= 1'b1;
                    count_err <= 1'b0;
                    rd_en <= 1'b1;
                    rd_addr <= '0;
                end
                CNT_RD: state <= CNT_WAIT;
                CNT_WAIT: if (tail_v && tail_a == '0) begin
                    particle_count <= clamped;
                    count_err <= raw > MAX_CNT;
                    if (clamped == '0) begin
                        state <= FIN;
                        done <= 1'b1;
                        busy <= 1'b0;
                    end else begin
                        rd_en <= 1'b1;
                        rd_addr <= ONE;
                        next_addr <= ONE + ONE;
                        state <= clamped == ONE ? DRAIN : STREAM;
                    end
                end
                STREAM: if (credit) begin
                    rd_en <= 1'b1;
                    rd_addr <= next_addr;
                    next_addr <= next_addr + 1'b1;
                    if (next_addr == particle_count) state <= DRAIN;
                end
                DRAIN: if (drained) begin
                    state <= FIN;
                    done <= 1'b1;
                    busy <= 1'b0;
                end
                FIN: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cell_pos_streamer.sv
// tb_cell_pos_streamer: random cell contents streamed and compared against the expected particle list
module tb_cell_pos_streamer;
    logic clk = 0, rst = 1, start = 0, out_ready = 1;
    logic busy, done, count_err, rd_en, out_valid;
    logic [7:0] particle_count, rd_addr, out_index;
    logic [95:0] rd_data = '0, out_data, q1 = '0;
    logic [95:0] mem [256];
    int n_chk = 0, n_fail = 0, cyc = 0, rmode = 0;
    bit mon_en = 0;
    int exp_idx[$];
    logic [95:0] exp_dat[$];
    int xfers, dones, first_valid, last_xfer, done_cyc, issued, max_load, busy_cyc;

    cell_pos_streamer dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .count_err(count_err),
        .particle_count(particle_count), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .out_data(out_data), .out_index(out_index), .out_valid(out_valid), .out_ready(out_ready)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) begin
        if (rd_en) q1 <= mem[rd_addr];
        rd_data <= q1;
    end

    task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    initial begin
        int ph = 0;
        forever begin
            @(posedge clk);
            #1;
            ph++;
            case (rmode)
                0: out_ready = 1'b1;
                1: out_ready = (ph % 3 == 0);
                2: out_ready = 1'($urandom_range(0, 1));
                default: out_ready = 1'b0;
            endcase
        end
    end

    always @(negedge clk) if (mon_en) begin
        if (rd_en && rd_addr != 0) issued++;
        if (issued - xfers > max_load) max_load = issued - xfers;
        if (busy) busy_cyc++;
        if (out_valid && first_valid < 0) first_valid = cyc;
        if (out_valid && out_ready) begin
            if (exp_idx.size() == 0) check("extra transfer", 1, 0);
            else begin
                check("xfer index", 96'(out_index), 96'(exp_idx.pop_front()));
                check("xfer data", out_data, exp_dat.pop_front());
            end
            xfers++;
            last_xfer = cyc;
        end
        if (done) begin
            dones++;
            done_cyc = cyc;
        end
    end

    task automatic fill(input logic [7:0] raw, input bit pattern);
        mem[0] = {$urandom, $urandom, 24'($urandom), raw};
        for (int k = 1; k < 256; k++)
            mem[k] = pattern ? {3{32'(k) * 32'h10101}} : {$urandom, $urandom, $urandom};
    endtask

    task automatic pulse_start(output int t);
        @(posedge clk);
        #1;
        start = 1;
        t = cyc;
        @(posedge clk);
        #1;
        start = 0;
    endtask

    task automatic run(input logic [7:0] raw, input int mode, input bit restart);
        int n, t;
        n = raw > 219 ? 219 : int'(raw);
        exp_idx.delete();
        exp_dat.delete();
        for (int k = 1; k <= n; k++) begin
            exp_idx.push_back(k);
            exp_dat.push_back(mem[k]);
        end
        rmode = mode;
        {xfers, dones, issued, max_load, busy_cyc} = '0;
        {first_valid, last_xfer, done_cyc} = {-32'sd1, -32'sd1, -32'sd1};
        mon_en = 1;
        pulse_start(t);
        if (restart) begin
            repeat (3) @(posedge clk);
            #1 start = 1;
            @(posedge clk);
            #1 start = 0;
            repeat (4) @(posedge clk);
            #1 start = 1;
            @(posedge clk);
            #1 start = 0;
        end
        for (int i = 0; i < 4000 && dones == 0; i++) @(negedge clk);
        if (dones == 0) check("done timeout", 0, 1);
        repeat (8) @(negedge clk);
        check("done pulses", 96'(dones), 1);
        check("transfer count", 96'(xfers), 96'(n));
        check("particle_count", 96'(particle_count), 96'(n));
        check("count_err", 96'(count_err), 96'(raw > 219));
        check("credit bound", 96'(max_load > 4), 0);
        check("busy length", 96'(busy_cyc), 96'(done_cyc - t - 1));
        if (n == 0) begin
            check("done time cnt0", 96'(done_cyc), 96'(t + 4));
            check("no valid cnt0", 96'(first_valid), 96'(-1));
        end else begin
            check("first valid time", 96'(first_valid), 96'(t + 7));
            check("done after last", 96'(done_cyc), 96'(last_xfer + 1));
            if (mode == 0) check("last xfer time", 96'(last_xfer), 96'(t + 6 + n));
        end
        mon_en = 0;
    endtask

    task automatic check_zero(input string tag);
        check({tag, " busy"}, 96'(busy), 0);
        check({tag, " done"}, 96'(done), 0);
        check({tag, " count_err"}, 96'(count_err), 0);
        check({tag, " particle_count"}, 96'(particle_count), 0);
        check({tag, " rd_en"}, 96'(rd_en), 0);
        check({tag, " rd_addr"}, 96'(rd_addr), 0);
        check({tag, " out_valid"}, 96'(out_valid), 0);
        check({tag, " out_data"}, out_data, 0);
        check({tag, " out_index"}, 96'(out_index), 0);
    endtask

    initial begin
        int t;
        fill(0, 0);
        repeat (3) @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        check_zero("reset");
        run(0, 0, 0);
        fill(5, 1);
        run(5, 0, 0);
        fill(12, 0);
        run(12, 1, 0);
        fill(8'hFF, 0);
        run(8'hFF, 0, 0);
        fill(12, 0);
        rmode = 3;
        pulse_start(t);
        repeat (8) @(posedge clk);
        #1 rst = 1;
        @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        check_zero("mid-stream reset");
        fill(2, 0);
        run(2, 0, 0);
        fill(7, 0);
        run(7, 0, 1);
        for (int r = 0; r < 3; r++) begin
            logic [7:0] c;
            c = 8'($urandom_range(1, 40));
            fill(c, 0);
            run(c, 2, 0);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
